// File: rtl/spi_slave_byte.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_byte
//  Purpose  : SPI responder oversampled on sclk_common. Deserialises MOSI into
//             bytes pushed to an RX FIFO write port and serialises bytes from a
//             show-ahead TX FIFO onto MISO, MSB first. Frames are delimited by
//             spi_n_cs; each frame is expected to carry BYTES_PER_FRAME bytes.
//  Ports    :
//    sclk_common  in   oversampling clock (>= 8x spi_sclk)
//    n_rst        in   asynchronous active-low reset
//    spi_n_cs     in   chip select from master (asynchronous)
//    spi_sclk     in   SPI clock from master (asynchronous)
//    spi_mosi     in   serial data from master (asynchronous)
//    spi_miso     out  serial data to master
//    spi_miso_oe  out  MISO output enable (high while a frame is active)
//    tx_data      in   TX FIFO head (show-ahead)
//    tx_empty     in   TX FIFO empty
//    tx_rdreq     out  TX FIFO pop, one-cycle pulse
//    rx_data      out  received byte
//    rx_wrreq     out  RX FIFO push, one-cycle pulse
//    byte_idx     out  index of the byte in progress within the frame
//    frame_done   out  pulse: frame closed with exactly BYTES_PER_FRAME bytes
//    frame_err    out  pulse: frame closed in any other state
//    tx_underrun  out  pulse: DEFAULT_TX substituted for an in-frame byte
//    busy         out  frame in progress
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_byte #(
  parameter int         CPOL            = 0,
  parameter int         CPHA            = 0,
  parameter int         BYTES_PER_FRAME = 2,
  parameter logic [7:0] DEFAULT_TX      = 8'hFF
) (
  input  logic       sclk_common,
  input  logic       n_rst,
  input  logic       spi_n_cs,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_rdreq,
  output logic [7:0] rx_data,
  output logic       rx_wrreq,
  output logic [7:0] byte_idx,
  output logic       frame_done,
  output logic       frame_err,
  output logic       tx_underrun,
  output logic       busy
);

  localparam logic       c_cpol = (CPOL != 0);
  localparam logic       c_cpha = (CPHA != 0);
  localparam logic [7:0] c_bpf  = 8'(BYTES_PER_FRAME);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic       cs_meta_q,   cs_meta_d;
  logic       cs_sync_q,   cs_sync_d;
  logic       cs_prev_q,   cs_prev_d;
  logic       sclk_meta_q, sclk_meta_d;
  logic       sclk_sync_q, sclk_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       mosi_meta_q, mosi_meta_d;
  logic       mosi_sync_q, mosi_sync_d;

  logic       armed_q,     armed_d;
  state_t     state_q,     state_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [7:0] byte_idx_q,  byte_idx_d;
  logic [6:0] rx_sr_q,     rx_sr_d;
  logic [6:0] tx_sr_q,     tx_sr_d;   // bits still to be sent after the one on MISO

  logic       miso_q,      miso_d;
  logic       miso_oe_q,   miso_oe_d;
  logic       busy_q,      busy_d;
  logic       tx_rdreq_q,  tx_rdreq_d;
  logic [7:0] rx_data_q,   rx_data_d;
  logic       rx_wrreq_q,  rx_wrreq_d;
  logic       done_q,      done_d;
  logic       err_q,       err_d;
  logic       under_q,     under_d;

  // --------------------------------------------------------------------------
  // Edge events on the synchronised bus
  // --------------------------------------------------------------------------
  logic cs_fall, cs_rise;
  logic sclk_rise, sclk_fall;
  logic lead_edge, trail_edge;
  logic sample_edge, shift_edge;

  assign cs_fall   = cs_prev_q & ~cs_sync_q;
  assign cs_rise   = ~cs_prev_q & cs_sync_q;
  assign sclk_rise = ~sclk_prev_q & sclk_sync_q;
  assign sclk_fall = sclk_prev_q & ~sclk_sync_q;

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead_edge   = c_cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = c_cpol ? sclk_rise : sclk_fall;
  assign sample_edge = c_cpha ? trail_edge : lead_edge;
  assign shift_edge  = c_cpha ? lead_edge  : trail_edge;

  // --------------------------------------------------------------------------
  // Byte load source
  // --------------------------------------------------------------------------
  logic       frame_start;
  logic       shift_load_ok;
  logic       do_load;
  logic [7:0] load_idx;
  logic       load_in_frame;
  logic [7:0] load_byte;
  logic       load_pop;
  logic       load_under;

  assign frame_start = (state_q == ST_IDLE) & cs_fall & armed_q;

  // With CPHA=0 the first byte is loaded at n_cs fall, so the shift edge only
  // loads on later byte boundaries; with CPHA=1 every byte is loaded on a
  // shift edge, including the first.
  assign shift_load_ok = (bit_cnt_q == 3'd0) & (c_cpha | (byte_idx_q != 8'd0));

  assign do_load = (frame_start & ~c_cpha) |
                   ((state_q == ST_ACTIVE) & ~cs_rise & shift_edge & shift_load_ok);

  // byte_idx_q still holds the previous frame's count while idle, so the
  // frame-start load must look at index 0.
  assign load_idx      = (state_q == ST_IDLE) ? 8'd0 : byte_idx_q;
  assign load_in_frame = (load_idx < c_bpf);
  assign load_pop      = load_in_frame & ~tx_empty;
  assign load_under    = load_in_frame & tx_empty;
  assign load_byte     = load_pop ? tx_data : DEFAULT_TX;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    cs_meta_d   = spi_n_cs;
    cs_sync_d   = cs_meta_q;
    cs_prev_d   = cs_sync_q;
    sclk_meta_d = spi_sclk;
    sclk_sync_d = sclk_meta_q;
    sclk_prev_d = sclk_sync_q;
    mosi_meta_d = spi_mosi;
    mosi_sync_d = mosi_meta_q;

    // Once n_cs has been seen high the bus is trusted until the next reset.
    armed_d     = armed_q | cs_sync_q;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    busy_d      = busy_q;
    rx_data_d   = rx_data_q;

    tx_rdreq_d  = 1'b0;
    rx_wrreq_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    under_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = 3'd0;
          byte_idx_d = 8'd0;
          rx_sr_d    = 7'd0;
          busy_d     = 1'b1;
          miso_oe_d  = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (cs_rise) begin
          // Chip-select release wins over any coincident sample edge; an
          // unfinished byte is simply dropped.
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          miso_oe_d = 1'b0;
          miso_d    = 1'b1;
          if ((bit_cnt_q == 3'd0) && (byte_idx_q == c_bpf)) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (sample_edge) begin
            rx_sr_d   = {rx_sr_q[5:0], mosi_sync_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = {rx_sr_q, mosi_sync_q};
              rx_wrreq_d = 1'b1;
              if (byte_idx_q != 8'hFF) begin
                byte_idx_d = byte_idx_q + 8'd1;
              end
            end
          end
          if (shift_edge && !do_load) begin
            miso_d  = tx_sr_q[6];
            tx_sr_d = {tx_sr_q[5:0], 1'b0};
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The loaded MSB is presented on MISO in the load cycle itself.
    if (do_load) begin
      miso_d     = load_byte[7];
      tx_sr_d    = load_byte[6:0];
      tx_rdreq_d = load_pop;
      under_d    = load_under;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sclk_common or negedge n_rst) begin
    if (!n_rst) begin
      // n_cs synchronisers reset low so that a bus already selected at reset
      // release never arms the block before a genuine high is seen.
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
      sclk_meta_q <= c_cpol;
      sclk_sync_q <= c_cpol;
      sclk_prev_q <= c_cpol;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_idx_q  <= 8'd0;
      rx_sr_q     <= 7'd0;
      tx_sr_q     <= 7'd0;
      miso_q      <= 1'b1;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_rdreq_q  <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_wrreq_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      cs_meta_q   <= cs_meta_d;
      cs_sync_q   <= cs_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_meta_q <= sclk_meta_d;
      sclk_sync_q <= sclk_sync_d;
      sclk_prev_q <= sclk_prev_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
      tx_rdreq_q  <= tx_rdreq_d;
      rx_data_q   <= rx_data_d;
      rx_wrreq_q  <= rx_wrreq_d;
      done_q      <= done_d;
      err_q       <= err_d;
      under_q     <= under_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = miso_oe_q;
  assign busy        = busy_q;
  assign tx_rdreq    = tx_rdreq_q;
  assign rx_data     = rx_data_q;
  assign rx_wrreq    = rx_wrreq_q;
  assign byte_idx    = byte_idx_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign tx_underrun = under_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_byte.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_byte
//  Purpose  : Self-checking bench for spi_slave_byte. Four instances cover the
//             four CPOL/CPHA modes (instance index = {CPOL,CPHA}); a shared TX
//             FIFO model feeds them and a monitor logs RX pushes and pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_byte;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] ncs  = 4'hF;
  logic [3:0] sck  = 4'b1100;   // idle level = CPOL of each instance
  logic [3:0] mosi = 4'h0;

  wire  [3:0] miso, miso_oe, tx_rdreq, rx_wrreq, done, err, under, busy;
  wire  [7:0] rx_data  [4];
  wire  [7:0] byte_idx [4];

  // TX FIFO model: memory and write pointer owned by the stimulus, read pointer
  // owned by the monitor.
  logic [7:0] fifo_mem [16];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  wire  [7:0] fifo_head = fifo_mem[rd_ptr[3:0]];
  wire        fifo_empty = (rd_ptr == wr_ptr);

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    spi_slave_byte #(
      .CPOL(i / 2), .CPHA(i % 2), .BYTES_PER_FRAME(2), .DEFAULT_TX(8'hFF)
    ) u_dut (
      .sclk_common(clk),        .n_rst(n_rst),
      .spi_n_cs(ncs[i]),        .spi_sclk(sck[i]),      .spi_mosi(mosi[i]),
      .spi_miso(miso[i]),       .spi_miso_oe(miso_oe[i]),
      .tx_data(fifo_head),      .tx_empty(fifo_empty),  .tx_rdreq(tx_rdreq[i]),
      .rx_data(rx_data[i]),     .rx_wrreq(rx_wrreq[i]), .byte_idx(byte_idx[i]),
      .frame_done(done[i]),     .frame_err(err[i]),     .tx_underrun(under[i]),
      .busy(busy[i])
    );
  end

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  logic [7:0] rx_log [64];
  int rx_wr_cnt = 0;
  int cnt_rd = 0, cnt_un = 0, cnt_dn = 0, cnt_er = 0;

  always @(negedge clk) begin
    if (|tx_rdreq) rd_ptr <= rd_ptr + 1;
    cnt_rd <= cnt_rd + $countones(tx_rdreq);
    cnt_un <= cnt_un + $countones(under);
    cnt_dn <= cnt_dn + $countones(done);
    cnt_er <= cnt_er + $countones(err);
    for (int i = 0; i < 4; i++) begin
      if (rx_wrreq[i]) begin
        rx_log[rx_wr_cnt[5:0]] <= rx_data[i];
        rx_wr_cnt <= rx_wr_cnt + 1;
      end
    end
  end

  // Scoreboard
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  int rx_rd = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int b_rd, b_un, b_dn, b_er;

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 1;
    exp_miso.push_back(b);
  endtask

  task automatic snap();
    b_rd = cnt_rd; b_un = cnt_un; b_dn = cnt_dn; b_er = cnt_er;
  endtask

  task automatic check_counts(input string t, input int rd, input int un,
                              input int dn, input int er);
    check({t, "_rdreq"},    cnt_rd - b_rd, rd);
    check({t, "_underrun"}, cnt_un - b_un, un);
    check({t, "_done"},     cnt_dn - b_dn, dn);
    check({t, "_err"},      cnt_er - b_er, er);
  endtask

  task automatic check_rx(input string t);
    check({t, "_rxcnt"}, rx_wr_cnt - rx_rd, exp_rx.size());
    while (rx_rd < rx_wr_cnt && exp_rx.size() > 0) begin
      check({t, "_rxbyte"}, rx_log[rx_rd[5:0]], exp_rx.pop_front());
      rx_rd++;
    end
    rx_rd = rx_wr_cnt;
    exp_rx.delete();
  endtask

  // Master: drives nbits of data (MSB first) on instance m, captures MISO at
  // each sample edge. sclk half period is 4 sclk_common cycles.
  task automatic xfer(input int m, input int nbits, input logic [23:0] data,
                      output logic [23:0] got);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    got = 24'd0;
    ncs[m] = 1'b0;
    if (!cpha) mosi[m] = data[23];
    wclk(8);
    for (int b = 0; b < nbits; b++) begin
      if (cpha) begin
        sck[m] = ~cpol; mosi[m] = data[23-b]; wclk(4);
        sck[m] = cpol;  got[23-b] = miso[m];  wclk(4);
      end else begin
        sck[m] = ~cpol; got[23-b] = miso[m];  wclk(4);
        sck[m] = cpol;
        if (b + 1 < nbits) mosi[m] = data[22-b];
        wclk(4);
      end
    end
    wclk(4);
    check($sformatf("m%0d_busy_in_frame", m), {busy[m], miso_oe[m]}, 2'b11);
    ncs[m] = 1'b1;
    wclk(16);
    check($sformatf("m%0d_idle_after", m), {busy[m], miso_oe[m], miso[m]}, 3'b001);
  endtask

  task automatic frame(input int m, input int nbits, input logic [23:0] data);
    logic [23:0] got;
    int nb;
    nb = nbits / 8;
    snap();
    for (int k = 0; k < nb; k++) exp_rx.push_back(data[23-8*k -: 8]);
    xfer(m, nbits, data, got);
    for (int k = 0; k < nb; k++)
      check($sformatf("m%0d_miso_byte%0d", m, k), got[23-8*k -: 8], exp_miso.pop_front());
    check_rx($sformatf("m%0d", m));
  endtask

  initial begin
    // Reset state
    wclk(4);
    check("rst_miso",    miso, 4'hF);
    check("rst_oe_busy", {miso_oe, busy}, 8'h00);
    check("rst_pulses",  {tx_rdreq, rx_wrreq, done, err, under}, 20'h0);
    check("rst_rx_data", {rx_data[0], rx_data[3]}, 16'h0);
    check("rst_byte_idx", {byte_idx[0], byte_idx[3]}, 16'h0);
    n_rst = 1'b1;
    wclk(8);

    // Mode 0 basic: TX A5,3C; RX 12,34
    fifo_push(8'hA5); fifo_push(8'h3C);
    frame(0, 16, {8'h12, 8'h34, 8'h00});
    check_counts("basic", 2, 0, 1, 0);

    // All four modes
    for (int m = 0; m < 4; m++) begin
      fifo_push(8'hC3); fifo_push(8'h5A);
      frame(m, 16, {8'h81, 8'h7E, 8'h00});
      check_counts($sformatf("mode%0d", m), 2, 0, 1, 0);
    end

    // Empty TX FIFO: DEFAULT_TX on both bytes
    exp_miso.push_back(8'hFF); exp_miso.push_back(8'hFF);
    frame(0, 16, {8'h6E, 8'h91, 8'h00});
    check_counts("underrun", 0, 2, 1, 0);

    // Truncated frame after 13 bits, then a clean frame
    fifo_push(8'h55); fifo_push(8'hAA);
    frame(0, 13, {8'hC6, 8'h9B, 8'h00});
    void'(exp_miso.pop_front());
    check_counts("trunc", 2, 0, 0, 1);
    fifo_push(8'h0F); fifo_push(8'hF0);
    frame(0, 16, {8'h3A, 8'hE5, 8'h00});
    check_counts("after_trunc", 2, 0, 1, 0);

    // Three bytes with BYTES_PER_FRAME=2
    fifo_push(8'h11); fifo_push(8'h22); exp_miso.push_back(8'hFF);
    frame(0, 24, {8'hDE, 8'hAD, 8'hBE});
    check_counts("extra", 2, 0, 0, 1);
    check("fifo_drained", fifo_empty, 1'b1);

    // Reset released mid-frame with the bus selected and clocking
    n_rst = 1'b0;
    ncs[0] = 1'b0;
    repeat (3) begin sck[0] = 1'b1; wclk(4); sck[0] = 1'b0; wclk(4); end
    n_rst = 1'b1;
    snap();
    repeat (24) begin
      mosi[0] = 1'($urandom_range(0, 1));
      sck[0] = 1'b1; wclk(4); sck[0] = 1'b0; wclk(4);
    end
    wclk(8);
    check_rx("unarmed");
    check("unarmed_busy", busy[0], 1'b0);
    check_counts("unarmed", 0, 0, 0, 0);
    ncs[0] = 1'b1;
    wclk(8);
    fifo_push(8'h77); fifo_push(8'h88);
    frame(0, 16, {8'h4C, 8'hB2, 8'h00});
    check_counts("rearmed", 2, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
